// File: rtl/posit_mul_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : posit_sched_pkg
// Description : Shared types, constants and helpers for the posit multiplier
//               scheduler. Holds the posit special encodings, the tag carried
//               alongside each issued multiply, and NaR/zero classifiers.
// Contents    : POSIT_W, TAG_ID_W, POSIT_NAR, POSIT_ZERO, sched_tag_t,
//               is_nar(), is_zero()
// Revision    : 1.0 - initial release
// ============================================================================
package posit_sched_pkg;

  localparam int POSIT_W  = 32;
  // Tag id field is sized for up to 256 requesters; the scheduler uses only
  // the low $clog2(N_REQ) bits.
  localparam int TAG_ID_W = 8;

  localparam logic [POSIT_W-1:0] POSIT_NAR  = 32'h8000_0000;
  localparam logic [POSIT_W-1:0] POSIT_ZERO = 32'h0000_0000;

  // One entry of the tag pipeline that runs in parallel with the multiplier.
  typedef struct packed {
    logic                valid;
    logic                bypass;
    logic [POSIT_W-1:0]  bypass_val;
    logic [TAG_ID_W-1:0] id;
  } sched_tag_t;

  function automatic logic is_nar(input logic [POSIT_W-1:0] v);
    return v == POSIT_NAR;
  endfunction

  function automatic logic is_zero(input logic [POSIT_W-1:0] v);
    return v == POSIT_ZERO;
  endfunction

endpackage
`default_nettype wire

// File: rtl/posit_mul_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : posit_mul_scheduler_if
// Description : Requester and response handshake bundle of the posit
//               multiplier scheduler.
// Signals     : req_valid/req_ready [N_REQ]   per-requester handshake
//               req_a/req_b [N_REQ*W]         operands, requester i at [i*W +: W]
//               rsp_valid/rsp_ready           result handshake
//               rsp_id [$clog2(N_REQ)]        requester index of the result
//               rsp_data [W]                  product
// Modports    : master - requesters/consumer side, slave - scheduler side
// Revision    : 1.0 - initial release
// ============================================================================
interface posit_mul_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int W     = posit_sched_pkg::POSIT_W
) ();

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [W-1:0]       rsp_data;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface
`default_nettype wire

// File: rtl/posit_mul_scheduler_arb.sv
`default_nettype none
// ============================================================================
// Module      : posit_rr_arbiter
// Description : Round-robin arbiter. Search starts at the rotating pointer;
//               the pointer moves to one past the granted index only when the
//               grant is actually consumed (i_advance).
// Ports       : clk, rst          clock, asynchronous active-high reset
//               i_req [N_REQ]     request vector
//               i_advance         grant was accepted this cycle
//               o_grant [N_REQ]   one-hot grant (combinational)
//               o_grant_idx       binary index of the grant
//               o_any             some request is granted
// Revision    : 1.0 - initial release
// ============================================================================
module posit_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic [N_REQ-1:0]         i_req,
  input  wire logic                     i_advance,
  output logic      [N_REQ-1:0]         o_grant,
  output logic      [$clog2(N_REQ)-1:0] o_grant_idx,
  output logic                          o_any
);

  localparam int c_IDX_W = $clog2(N_REQ);
  localparam int c_POS_W = c_IDX_W + 1;
  localparam logic [c_POS_W-1:0] c_N    = c_POS_W'(N_REQ);
  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(N_REQ - 1);
  localparam logic [c_IDX_W-1:0] c_ONE  = c_IDX_W'(1);

  logic [c_IDX_W-1:0] r_ptr;
  logic [N_REQ-1:0]   w_grant;
  logic [c_IDX_W-1:0] w_idx;
  logic               w_found;
  logic [c_POS_W-1:0] w_pos;

  // Walk the requesters starting at r_ptr; the one extra bit in w_pos lets
  // the modulo-N wrap work for non-power-of-two N_REQ.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos = {1'b0, r_ptr} + c_POS_W'(k);
      if (w_pos >= c_N) begin
        w_pos = w_pos - c_N;
      end
      if (!w_found && i_req[w_pos[c_IDX_W-1:0]]) begin
        w_found                     = 1'b1;
        w_grant[w_pos[c_IDX_W-1:0]] = 1'b1;
        w_idx                       = w_pos[c_IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance && w_found) begin
      r_ptr <= (w_idx == c_LAST) ? '0 : w_idx + c_ONE;
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_idx = w_idx;
  assign o_any       = w_found;

endmodule
`default_nettype wire

// File: rtl/posit_mul_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : posit_mul_scheduler
// Description : Shares one posit multiplier among N_REQ requesters. Round-robin
//               arbitration, credit-limited issue, NaR/zero bypass around the
//               multiplier, and an in-order result FIFO with valid/ready.
// Ports       : clk, rst          clock, asynchronous active-high reset
//               bus (slave)       requester and response handshakes
//               mul_valid         live multiply on mul_a/mul_b
//               mul_a, mul_b      registered multiplier operands
//               mul_product       multiplier result, MUL_LAT after mul_valid
//               busy              op in flight or results queued
// Revision    : 1.0 - initial release
// ============================================================================
module posit_mul_scheduler
  import posit_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int W         = POSIT_W,
  parameter int MUL_LAT   = 2,
  parameter int OUT_DEPTH = 4
) (
  input  wire logic               clk,
  input  wire logic               rst,
  posit_mul_scheduler_if.slave    bus,
  output logic                    mul_valid,
  output logic      [W-1:0]       mul_a,
  output logic      [W-1:0]       mul_b,
  input  wire logic [W-1:0]       mul_product,
  output logic                    busy
);

  localparam int c_ID_W  = $clog2(N_REQ);
  localparam int c_CR_W  = $clog2(OUT_DEPTH + 1);
  localparam int c_PTR_W = $clog2(OUT_DEPTH);
  localparam logic [c_CR_W-1:0]  c_DEPTH    = c_CR_W'(OUT_DEPTH);
  localparam logic [c_CR_W-1:0]  c_CR_ONE   = c_CR_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(OUT_DEPTH - 1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

  // --------------------------------------------------------------------------
  // Arbitration and issue
  // --------------------------------------------------------------------------
  logic [N_REQ-1:0]  w_grant;
  logic [c_ID_W-1:0] w_grant_idx;
  logic              w_any;
  logic              w_accept;
  logic              w_pop;
  logic              w_can_issue;
  logic              r_run;
  logic [c_CR_W-1:0] r_credits;

  posit_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_req       (bus.req_valid),
    .i_advance   (w_accept),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  // Keeps req_ready low for the whole reset and releases it one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // A pop in the same cycle frees the slot this accept will eventually use,
  // so an accept at zero credits is safe when a pop coincides. This sustains
  // one accept per cycle with the result path draining.
  assign w_can_issue   = r_run && ((r_credits != '0) || w_pop);
  assign bus.req_ready = w_grant & {N_REQ{w_can_issue}};
  assign w_accept      = w_any && w_can_issue;

  logic [W-1:0] w_op_a;
  logic [W-1:0] w_op_b;

  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_op_a = bus.req_a[i*W +: W];
        w_op_b = bus.req_b[i*W +: W];
      end
    end
  end

  // NaR dominates zero: NaR x 0 is NaR.
  logic         w_nar;
  logic         w_zero;
  logic         w_bypass;
  logic [W-1:0] w_bypass_val;

  assign w_nar        = is_nar(w_op_a) || is_nar(w_op_b);
  assign w_zero       = is_zero(w_op_a) || is_zero(w_op_b);
  assign w_bypass     = w_nar || w_zero;
  assign w_bypass_val = w_nar ? POSIT_NAR : POSIT_ZERO;

  logic         r_mul_valid;
  logic [W-1:0] r_mul_a;
  logic [W-1:0] r_mul_b;

  // Operands are held when idle or bypassing so the multiplier inputs do not
  // toggle needlessly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mul_valid <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
    end else if (w_accept && !w_bypass) begin
      r_mul_valid <= 1'b1;
      r_mul_a     <= w_op_a;
      r_mul_b     <= w_op_b;
    end else begin
      r_mul_valid <= 1'b0;
    end
  end

  assign mul_valid = r_mul_valid;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;

  // --------------------------------------------------------------------------
  // Tag pipeline: stage k is live in the same cycle the multiply is k cycles
  // old, so the last stage lines up with mul_product.
  // --------------------------------------------------------------------------
  sched_tag_t r_tag [0:MUL_LAT];
  sched_tag_t w_tag_in;
  sched_tag_t w_tag_out;

  always_comb begin
    w_tag_in            = '0;
    w_tag_in.valid      = w_accept;
    w_tag_in.bypass     = w_bypass;
    w_tag_in.bypass_val = w_bypass_val;
    w_tag_in.id         = TAG_ID_W'(w_grant_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= MUL_LAT; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      r_tag[0] <= w_tag_in;
      for (int k = 1; k <= MUL_LAT; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  assign w_tag_out = r_tag[MUL_LAT];

  logic              w_push;
  logic [W-1:0]      w_push_data;
  logic [c_ID_W-1:0] w_push_id;
  logic              w_unused_tag_id;

  assign w_push          = w_tag_out.valid;
  assign w_push_data     = w_tag_out.bypass ? w_tag_out.bypass_val : mul_product;
  assign w_push_id       = w_tag_out.id[c_ID_W-1:0];
  assign w_unused_tag_id = ^w_tag_out.id;

  // --------------------------------------------------------------------------
  // Result FIFO. Count is kept separately so full and empty never alias.
  // --------------------------------------------------------------------------
  logic [c_ID_W-1:0]  r_fifo_id   [OUT_DEPTH];
  logic [W-1:0]       r_fifo_data [OUT_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CR_W-1:0]  r_count;

  assign bus.rsp_valid = (r_count != '0);
  assign bus.rsp_id    = r_fifo_id[r_rd_ptr];
  assign bus.rsp_data  = r_fifo_data[r_rd_ptr];
  assign w_pop         = bus.rsp_valid && bus.rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < OUT_DEPTH; k++) begin
        r_fifo_id[k]   <= '0;
        r_fifo_data[k] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_id[r_wr_ptr]   <= w_push_id;
        r_fifo_data[r_wr_ptr] <= w_push_data;
        r_wr_ptr              <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CR_ONE;
        2'b01:   r_count <= r_count - c_CR_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Credits = OUT_DEPTH - fifo_count - inflight, tracked incrementally.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits <= c_DEPTH;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_credits <= r_credits - c_CR_ONE;
        2'b01:   r_credits <= r_credits + c_CR_ONE;
        default: r_credits <= r_credits;
      endcase
    end
  end

  assign busy = (r_credits != c_DEPTH);

endmodule
`default_nettype wire
